// File: rtl/spi_mosi_slave_rx_if.sv
// Bus bundle between the MOSI transmitter (or bench) and the receiver.
// Serial lines flow master -> slave; reassembled words flow back.
interface spi_mosi_slave_rx_if #(
    parameter int WIDTH = 8
);
    logic             sck;
    logic             cs;
    logic             mosi;
    logic             dc;
    logic [WIDTH-1:0] data;
    logic             data_dc;
    logic             valid;
    logic             frame_err;
    logic             busy;
    logic [7:0]       byte_cnt;

    modport master (
        output sck, cs, mosi, dc,
        input  data, data_dc, valid, frame_err, busy, byte_cnt
    );

    modport slave (
        input  sck, cs, mosi, dc,
        output data, data_dc, valid, frame_err, busy, byte_cnt
    );
endinterface

// File: rtl/spi_mosi_slave_rx.sv
// Oversampling SPI mode-0 receiver: reassembles WIDTH-bit MSB-first words
// plus their D/C flag from asynchronous SCK/CS/MOSI/DC lines.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | CS high (or not yet seen falling); SCK edges ignored
// S_SHIFT | inside a CS-low frame; each SCK rise shifts in one bit
module spi_mosi_slave_rx #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               i_CLK,
    input  logic               i_RST,
    spi_mosi_slave_rx_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] dc_sync;
    logic                   sck_d;
    logic                   cs_d;

    logic                   sck_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   dc_s;
    logic                   sck_rise;
    logic                   cs_fall;
    logic                   cs_rise;

    logic [0:0]             state;
    logic [CNT_W-1:0]       bit_cnt;
    // Only WIDTH-1 bits are retained; the current bit completes the word.
    logic [WIDTH-2:0]       shift_q;
    logic [WIDTH-1:0]       shift_next;

    logic [WIDTH-1:0]       data_q;
    logic                   data_dc_q;
    logic                   valid_q;
    logic                   frame_err_q;
    logic [7:0]             byte_cnt_q;

    // Equal-depth synchronizers on all lines keep MOSI/DC aligned with SCK;
    // CS resets high so releasing reset never looks like a CS fall.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            dc_sync   <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            dc_sync   <= {dc_sync[SYNC_STAGES-2:0], bus.dc};
            sck_d     <= sck_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sck_s      = sck_sync[SYNC_STAGES-1];
    assign cs_s       = cs_sync[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync[SYNC_STAGES-1];
    assign dc_s       = dc_sync[SYNC_STAGES-1];
    assign sck_rise   = sck_s & ~sck_d;
    assign cs_fall    = ~cs_s & cs_d;
    assign cs_rise    = cs_s & ~cs_d;
    assign shift_next = {shift_q, mosi_s};

    // Frame/word sequencing; CS edges take priority over a coincident SCK rise.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            data_dc_q   <= 1'b0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            byte_cnt_q  <= '0;
        end else begin
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cs_fall) begin
                        state      <= S_SHIFT;
                        bit_cnt    <= '0;
                        byte_cnt_q <= '0;
                    end
                end
                S_SHIFT: begin
                    if (cs_rise) begin
                        state   <= S_IDLE;
                        bit_cnt <= '0;
                        if (bit_cnt != '0) begin
                            frame_err_q <= 1'b1;
                        end
                    end else if (sck_rise) begin
                        shift_q <= shift_next[WIDTH-2:0];
                        if (bit_cnt == LAST_BIT) begin
                            data_q    <= shift_next;
                            data_dc_q <= dc_s;
                            valid_q   <= 1'b1;
                            bit_cnt   <= '0;
                            if (byte_cnt_q != 8'hFF) begin
                                byte_cnt_q <= byte_cnt_q + 8'd1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.data_dc   = data_dc_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state == S_SHIFT);
    assign bus.byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_spi_mosi_slave_rx.sv
// Directed bench for spi_mosi_slave_rx: an 8-bit and a 16-bit receiver
// listen to the same serial lines driven from the tasks below.
module tb_spi_mosi_slave_rx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sck = 1'b0;
    logic cs = 1'b1;
    logic mosi = 1'b0;
    logic dc = 1'b0;

    int checks = 0;
    int errors = 0;

    spi_mosi_slave_rx_if #(.WIDTH(8))  bus8 ();
    spi_mosi_slave_rx_if #(.WIDTH(16)) bus16 ();

    assign bus8.sck   = sck;
    assign bus8.cs    = cs;
    assign bus8.mosi  = mosi;
    assign bus8.dc    = dc;
    assign bus16.sck  = sck;
    assign bus16.cs   = cs;
    assign bus16.mosi = mosi;
    assign bus16.dc   = dc;

    spi_mosi_slave_rx #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
        .i_CLK (clk),
        .i_RST (rst),
        .bus   (bus8.slave)
    );

    spi_mosi_slave_rx #(.WIDTH(16), .SYNC_STAGES(2)) dut16 (
        .i_CLK (clk),
        .i_RST (rst),
        .bus   (bus16.slave)
    );

    always #5 clk = ~clk;

    // Observation of output pulses, sampled on the falling clock edge.
    int          valid_total = 0;
    int          ferr_total = 0;
    int          valid_long = 0;
    logic        valid_prev = 1'b0;
    logic [7:0]  last_data = '0;
    logic        last_dc = 1'b0;
    logic [7:0]  prev_data = '0;
    logic        prev_dc = 1'b0;
    logic        ferr_busy = 1'b0;
    int          valid16_total = 0;
    logic [15:0] last_data16 = '0;
    logic        last_dc16 = 1'b0;

    always @(negedge clk) begin
        if (bus8.valid) begin
            valid_total++;
            prev_data = last_data;
            prev_dc   = last_dc;
            last_data = bus8.data;
            last_dc   = bus8.data_dc;
            if (valid_prev) valid_long++;
        end
        valid_prev = bus8.valid;
        if (bus8.frame_err) begin
            ferr_total++;
            ferr_busy = bus8.busy;
        end
        if (bus16.valid) begin
            valid16_total++;
            last_data16 = bus16.data;
            last_dc16   = bus16.data_dc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] word, input logic dcb,
                             input int width, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            mosi = word[width-1-i];
            dc   = dcb;
            tick(2);
            sck = 1'b1;
            tick(3);
            sck = 1'b0;
            tick(1);
        end
    endtask

    task automatic frame_start();
        cs = 1'b0;
        tick(4);
    endtask

    task automatic frame_end();
        tick(2);
        cs = 1'b1;
        tick(6);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(4);
        checks++; if (bus8.data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", bus8.data); end
        checks++; if (bus8.data_dc !== 1'b0) begin errors++; $display("FAIL reset_dc got %b want 0", bus8.data_dc); end
        checks++; if (bus8.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus8.valid); end
        checks++; if (bus8.frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", bus8.frame_err); end
        checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus8.busy); end
        checks++; if (bus8.byte_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", bus8.byte_cnt); end
        rst = 1'b0;
        tick(4);
        checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b want 0", bus8.busy); end
    endtask

    task automatic test_single_word();
        int vb, fb;
        vb = valid_total;
        fb = ferr_total;
        frame_start();
        checks++; if (bus8.busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", bus8.busy); end
        send_bits(32'hA5, 1'b0, 8, 7);
        mosi = 1'b1;
        dc   = 1'b0;
        tick(2);
        sck = 1'b1;
        tick(2);
        checks++; if (bus8.valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b want 0", bus8.valid); end
        tick(1);
        checks++; if (bus8.valid !== 1'b1) begin errors++; $display("FAIL single_latency_valid got %b want 1", bus8.valid); end
        checks++; if (bus8.data !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", bus8.data); end
        checks++; if (bus8.byte_cnt !== 8'd1) begin errors++; $display("FAIL single_cnt got %0d want 1", bus8.byte_cnt); end
        tick(1);
        checks++; if (bus8.valid !== 1'b0) begin errors++; $display("FAIL single_valid_width got %b want 0", bus8.valid); end
        sck = 1'b0;
        tick(1);
        frame_end();
        checks++; if (valid_total - vb !== 1) begin errors++; $display("FAIL single_nvalid got %0d want 1", valid_total - vb); end
        checks++; if (last_dc !== 1'b0) begin errors++; $display("FAIL single_dc got %b want 0", last_dc); end
        checks++; if (ferr_total - fb !== 0) begin errors++; $display("FAIL single_ferr got %0d want 0", ferr_total - fb); end
        checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b want 0", bus8.busy); end
        checks++; if (bus8.byte_cnt !== 8'd1) begin errors++; $display("FAIL single_cnt_end got %0d want 1", bus8.byte_cnt); end
    endtask

    task automatic test_back_to_back();
        int vb, fb;
        vb = valid_total;
        fb = ferr_total;
        frame_start();
        send_bits(32'h81, 1'b0, 8, 8);
        send_bits(32'h3C, 1'b1, 8, 8);
        frame_end();
        checks++; if (valid_total - vb !== 2) begin errors++; $display("FAIL b2b_nvalid got %0d want 2", valid_total - vb); end
        checks++; if (prev_data !== 8'h81) begin errors++; $display("FAIL b2b_data0 got %h want 81", prev_data); end
        checks++; if (prev_dc !== 1'b0) begin errors++; $display("FAIL b2b_dc0 got %b want 0", prev_dc); end
        checks++; if (last_data !== 8'h3C) begin errors++; $display("FAIL b2b_data1 got %h want 3c", last_data); end
        checks++; if (last_dc !== 1'b1) begin errors++; $display("FAIL b2b_dc1 got %b want 1", last_dc); end
        checks++; if (bus8.byte_cnt !== 8'd2) begin errors++; $display("FAIL b2b_cnt got %0d want 2", bus8.byte_cnt); end
        checks++; if (ferr_total - fb !== 0) begin errors++; $display("FAIL b2b_ferr got %0d want 0", ferr_total - fb); end
    endtask

    task automatic test_abort();
        int vb, fb;
        vb = valid_total;
        fb = ferr_total;
        frame_start();
        send_bits(32'hF0, 1'b0, 8, 5);
        frame_end();
        checks++; if (ferr_total - fb !== 1) begin errors++; $display("FAIL abort_ferr got %0d want 1", ferr_total - fb); end
        checks++; if (ferr_busy !== 1'b0) begin errors++; $display("FAIL abort_ferr_busy got %b want 0", ferr_busy); end
        checks++; if (valid_total - vb !== 0) begin errors++; $display("FAIL abort_nvalid got %0d want 0", valid_total - vb); end
        checks++; if (bus8.data !== 8'h3C) begin errors++; $display("FAIL abort_data got %h want 3c", bus8.data); end
        checks++; if (bus8.data_dc !== 1'b1) begin errors++; $display("FAIL abort_dc got %b want 1", bus8.data_dc); end
        checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", bus8.busy); end
        checks++; if (bus8.byte_cnt !== 8'd0) begin errors++; $display("FAIL abort_cnt got %0d want 0", bus8.byte_cnt); end
    endtask

    task automatic test_idle_sck();
        int vb, fb;
        vb = valid_total;
        fb = ferr_total;
        mosi = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sck = 1'b1;
            tick(2);
            sck = 1'b0;
            tick(2);
        end
        tick(4);
        checks++; if (valid_total - vb !== 0) begin errors++; $display("FAIL idle_nvalid got %0d want 0", valid_total - vb); end
        checks++; if (ferr_total - fb !== 0) begin errors++; $display("FAIL idle_ferr got %0d want 0", ferr_total - fb); end
        checks++; if (bus8.byte_cnt !== 8'd0) begin errors++; $display("FAIL idle_cnt got %0d want 0", bus8.byte_cnt); end
        checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", bus8.busy); end
    endtask

    task automatic test_reset_mid_word();
        int vb, fb;
        frame_start();
        send_bits(32'hFF, 1'b1, 8, 3);
        rst = 1'b1;
        cs  = 1'b1;
        sck = 1'b0;
        tick(3);
        checks++; if (bus8.data !== 8'h00) begin errors++; $display("FAIL midrst_data got %h want 00", bus8.data); end
        checks++; if (bus8.data_dc !== 1'b0) begin errors++; $display("FAIL midrst_dc got %b want 0", bus8.data_dc); end
        checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bus8.busy); end
        checks++; if (bus8.frame_err !== 1'b0) begin errors++; $display("FAIL midrst_ferr got %b want 0", bus8.frame_err); end
        checks++; if (bus8.valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", bus8.valid); end
        checks++; if (bus8.byte_cnt !== 8'd0) begin errors++; $display("FAIL midrst_cnt got %0d want 0", bus8.byte_cnt); end
        rst = 1'b0;
        tick(3);
        vb = valid_total;
        fb = ferr_total;
        frame_start();
        send_bits(32'hFF, 1'b1, 8, 8);
        frame_end();
        checks++; if (valid_total - vb !== 1) begin errors++; $display("FAIL midrst_nvalid got %0d want 1", valid_total - vb); end
        checks++; if (last_data !== 8'hFF) begin errors++; $display("FAIL midrst_word got %h want ff", last_data); end
        checks++; if (ferr_total - fb !== 0) begin errors++; $display("FAIL midrst_ferr_after got %0d want 0", ferr_total - fb); end
    endtask

    task automatic test_saturation();
        int vb;
        logic [31:0] w;
        vb = valid_total;
        frame_start();
        for (int i = 0; i < 300; i++) begin
            w = 32'(i) & 32'hFF;
            send_bits(w, w[0], 8, 8);
        end
        checks++; if (bus8.byte_cnt !== 8'd255) begin errors++; $display("FAIL sat_cnt got %0d want 255", bus8.byte_cnt); end
        frame_end();
        checks++; if (valid_total - vb !== 300) begin errors++; $display("FAIL sat_nvalid got %0d want 300", valid_total - vb); end
        checks++; if (last_data !== 8'h2B) begin errors++; $display("FAIL sat_last_data got %h want 2b", last_data); end
        checks++; if (last_dc !== 1'b1) begin errors++; $display("FAIL sat_last_dc got %b want 1", last_dc); end
        checks++; if (prev_data !== 8'h2A) begin errors++; $display("FAIL sat_prev_data got %h want 2a", prev_data); end
        checks++; if (bus8.byte_cnt !== 8'd255) begin errors++; $display("FAIL sat_cnt_end got %0d want 255", bus8.byte_cnt); end
    endtask

    task automatic test_width16();
        int vb;
        vb = valid16_total;
        frame_start();
        send_bits(32'hBEEF, 1'b1, 16, 16);
        frame_end();
        checks++; if (valid16_total - vb !== 1) begin errors++; $display("FAIL w16_nvalid got %0d want 1", valid16_total - vb); end
        checks++; if (last_data16 !== 16'hBEEF) begin errors++; $display("FAIL w16_data got %h want beef", last_data16); end
        checks++; if (last_dc16 !== 1'b1) begin errors++; $display("FAIL w16_dc got %b want 1", last_dc16); end
        checks++; if (bus16.byte_cnt !== 8'd1) begin errors++; $display("FAIL w16_cnt got %0d want 1", bus16.byte_cnt); end
        checks++; if (last_data !== 8'hEF) begin errors++; $display("FAIL w16_narrow_data got %h want ef", last_data); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_abort();
        test_idle_sck();
        test_reset_mid_word();
        test_saturation();
        test_width16();
        checks++; if (valid_long !== 0) begin errors++; $display("FAIL valid_pulse_width got %0d long pulses want 0", valid_long); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_mosi_slave_rx.md
# spi_mosi_slave_rx

Synchronous SPI receiver, mode 0 (sample on SCK rising edge, MSB first), running on the system clock. It oversamples the SCK, CS, MOSI and D/C lines produced by the team's MOSI transmitter and reassembles each WIDTH-bit word together with its D/C flag. It serves as the loopback checker and OLED-side model in the display subsystem, and as a generic command/data sink for FPGA-to-FPGA links.

## Interface
- WIDTH, 8: bits per word; legal range 2..32.
- SYNC_STAGES, 2: synchronizer flops per input line; legal range 2..4.

- i_CLK, input, 1: system clock; all logic on rising edge.
- i_RST, input, 1: reset, synchronous and active-high.
- i_SCK, input, 1: SPI serial clock (asynchronous to i_CLK).
- i_CS, input, 1: chip select, active low.
- i_MOSI, input, 1: serial data, MSB first.
- i_DC, input, 1: data/command flag (1 = data, 0 = command).
- o_DATA, output, WIDTH: last complete word received.
- o_DC, output, 1: D/C flag captured with o_DATA.
- o_VALID, output, 1: one-cycle pulse; o_DATA/o_DC are new.
- o_FRAME_ERR, output, 1: one-cycle pulse; CS deasserted mid-word.
- o_BUSY, output, 1: high while in SHIFT state.
- o_BYTE_CNT, output, 8: words completed in the current CS frame; saturates at 255.

## Operation
- Input conditioning:
  - i_SCK, i_CS, i_MOSI and i_DC each pass through SYNC_STAGES flops, followed by one delay flop on SCK and on CS for edge detection.
  - All four lines get an identical stage count, so their relative alignment is preserved.
  - SCK rise = synced 1 with delayed 0. CS fall and CS rise are detected the same way.
- Input constraint: each SCK high and low phase lasts ≥ 2 i_CLK periods. MOSI and DC are stable across the SCK rising edge, as the transmitter changes them on the falling edge.
- State machine (2 states):
  - IDLE: ignore SCK. On CS fall: go to SHIFT, clear the bit counter and o_BYTE_CNT.
  - SHIFT, on SCK rise:
    - Shift register <= {shift[WIDTH-2:0], mosi_sync}; bit counter +1.
    - On the WIDTH-th bit: load o_DATA with the full word (including the current bit) and o_DC with synced DC sampled on this same edge. Pulse o_VALID, increment o_BYTE_CNT (saturating), clear the bit counter, stay in SHIFT.
  - SHIFT, on CS rise: go to IDLE. If the bit counter ≠ 0, pulse o_FRAME_ERR and discard the partial word; o_DATA is unchanged.
- Back-to-back words within one CS-low frame need no gap. Each word can carry a different DC.
- Simultaneous CS rise and SCK rise in the same cycle: the CS rise wins and the SCK edge is dropped. The error check uses the pre-edge counter.
- Simultaneous CS fall and SCK rise: CS fall is processed and the SCK edge is ignored.
- i_RST (any state, including mid-word) clears:
  - all outputs to 0;
  - the shift register, bit counter and state (→ IDLE);
  - CS synchronizer and delay flops to 1, so no false CS fall follows reset;
  - SCK flops to 0.

## Timing
- Reset values: o_DATA=0, o_DC=0, o_VALID=0, o_FRAME_ERR=0, o_BUSY=0, o_BYTE_CNT=0.
- Latency: let edge k be the first i_CLK edge that samples i_SCK high for the last bit.
  - o_DATA, o_DC, o_VALID and o_BYTE_CNT update at edge k+SYNC_STAGES.
  - o_VALID is high for exactly one cycle.
- o_DATA and o_DC hold until the next o_VALID or reset. No consumer handshake; the sink must accept the pulse.
- o_BUSY rises at edge k+SYNC_STAGES after i_CS is first sampled low. It falls at the same offset after i_CS is sampled high.
- o_FRAME_ERR is asserted in the same cycle that o_BUSY falls.
- Minimum word period: 4·WIDTH i_CLK cycles.

## Test plan
- Single word: CS low, 0xA5 with DC=0, CS high.
  - Expect one o_VALID, o_DATA=0xA5, o_DC=0, o_BYTE_CNT=1, no o_FRAME_ERR.
- Back-to-back in one frame: 0x81 with DC=0, then 0x3C with DC=1, no SCK gap.
  - Expect two o_VALID pulses: (0x81,0) then (0x3C,1); o_BYTE_CNT=2.
- Abort: CS rises after 5 bits of 0xF0.
  - Expect an o_FRAME_ERR pulse, no o_VALID, o_DATA keeps its previous value, o_BUSY=0.
- SCK toggling 16 cycles with CS high.
  - Expect no o_VALID, o_BYTE_CNT unchanged, o_BUSY=0.
- Reset mid-word: assert i_RST after 3 bits, then send a full 0xFF frame.
  - Expect all outputs 0 after reset, then exactly one o_VALID with o_DATA=0xFF.
- Saturation and width: 300 words in one frame gives o_BYTE_CNT=255. Separately, WIDTH=16 with 0xBEEF and DC=1 gives o_DATA=0xBEEF, o_DC=1.
